// File: rtl/riscv_crypto_fu_ssm3_pkg.sv
// ---------------------------------------------------------------------------
// riscv_crypto_fu_ssm3_pkg
//  Shared definitions for the SM3 crypto functional units: FSM state
//  encodings, P0/P1 rotation constants, iteration counts and the op decoder.
//  No ports (package).
// ---------------------------------------------------------------------------
package riscv_crypto_fu_ssm3_pkg;

    // FSM states of the iterating permutation unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fu_state_e;

    // Which SM3 linear permutation a step applies.
    typedef enum logic {
        SEL_P0 = 1'b0,
        SEL_P1 = 1'b1
    } perm_sel_e;

    localparam int unsigned WORD_W = 32;

    // Rotation amounts: P0 = x ^ rol9 ^ rol17, P1 = x ^ rol15 ^ rol23.
    localparam int unsigned P0_ROT_A = 9;
    localparam int unsigned P0_ROT_B = 17;
    localparam int unsigned P1_ROT_A = 15;
    localparam int unsigned P1_ROT_B = 23;

    // Iteration counter width and step counts (P^4 = I, so inverse = P^3).
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] ITER_FWD = CNT_W'(1);
    localparam logic [CNT_W-1:0] ITER_INV = CNT_W'(3);

    // Decoded op: which permutation and how many steps to run.
    typedef struct packed {
        perm_sel_e        sel;
        logic [CNT_W-1:0] iters;
    } op_decode_t;

    // Rotate left of a 32-bit word by a constant amount in 1..31.
    function automatic logic [WORD_W-1:0] rol32(
        input logic [WORD_W-1:0] x,
        input int unsigned       n
    );
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Priority p0i > p1i > p0 > p1 keeps illegal multi-hot encodings deterministic.
    function automatic op_decode_t decode_op(
        input logic p0,
        input logic p1,
        input logic p0i,
        input logic p1i
    );
        op_decode_t d;
        d.sel   = SEL_P0;
        d.iters = ITER_FWD;
        if (p0i) begin
            d.sel   = SEL_P0;
            d.iters = ITER_INV;
        end else if (p1i) begin
            d.sel   = SEL_P1;
            d.iters = ITER_INV;
        end else if (p0) begin
            d.sel   = SEL_P0;
            d.iters = ITER_FWD;
        end else if (p1) begin
            d.sel   = SEL_P1;
            d.iters = ITER_FWD;
        end
        return d;
    endfunction

endpackage

// File: rtl/riscv_crypto_ssm3_perm.sv
// ---------------------------------------------------------------------------
// riscv_crypto_ssm3_perm
//  Combinational single step of the SM3 P0 or P1 linear permutation.
//  Ports:
//   x   in  32  input word
//   sel in  1   SEL_P0 / SEL_P1
//   y   out 32  P_sel(x)
// ---------------------------------------------------------------------------
module riscv_crypto_ssm3_perm
    import riscv_crypto_fu_ssm3_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  perm_sel_e         sel,
    output logic [WORD_W-1:0] y
);

    logic [WORD_W-1:0] p0_y;
    logic [WORD_W-1:0] p1_y;

    // Both permutations are cheap XOR trees; compute both and select.
    always_comb begin
        p0_y = x ^ rol32(x, P0_ROT_A) ^ rol32(x, P0_ROT_B);
        p1_y = x ^ rol32(x, P1_ROT_A) ^ rol32(x, P1_ROT_B);
        y    = (sel == SEL_P1) ? p1_y : p0_y;
    end

endmodule

// File: rtl/riscv_crypto_fu_ssm3_inv.sv
// ---------------------------------------------------------------------------
// riscv_crypto_fu_ssm3_inv
//  Multi-cycle FU computing SM3 P0/P1 and their inverses (P^3) by iterating
//  one permutation step per cycle.
//  Ports:
//   g_clk        in   1     clock
//   g_reset      in   1     synchronous active-high reset
//   valid        in   1     op request, held until ready
//   rs1          in   32    source operand
//   op_ssm3_p0   in   1     forward P0
//   op_ssm3_p1   in   1     forward P1
//   op_ssm3_p0i  in   1     inverse P0
//   op_ssm3_p1i  in   1     inverse P1
//   ready        out  1     one-cycle result strobe (decoded from state)
//   rd           out  XLEN  zero-extended result, 0 when ready=0
//  XLEN must be 32 or 64.
// ---------------------------------------------------------------------------
module riscv_crypto_fu_ssm3_inv
    import riscv_crypto_fu_ssm3_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              valid,
    input  logic [WORD_W-1:0] rs1,
    input  logic              op_ssm3_p0,
    input  logic              op_ssm3_p1,
    input  logic              op_ssm3_p0i,
    input  logic              op_ssm3_p1i,
    output logic              ready,
    output logic [XLEN-1:0]   rd
);

    fu_state_e         state_q;
    fu_state_e         state_d;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    perm_sel_e         sel_q;
    perm_sel_e         sel_d;

    logic              any_op;
    op_decode_t        dec;
    logic [WORD_W-1:0] perm_y;

    // One permutation step on the accumulator.
    riscv_crypto_ssm3_perm u_perm (
        .x   (acc_q),
        .sel (sel_q),
        .y   (perm_y)
    );

    // Op decode for the accept decision in IDLE.
    always_comb begin
        any_op = op_ssm3_p0 | op_ssm3_p1 | op_ssm3_p0i | op_ssm3_p1i;
        dec    = decode_op(op_ssm3_p0, op_ssm3_p1, op_ssm3_p0i, op_ssm3_p1i);
    end

    // State and datapath registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= SEL_P0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ready   = 1'b0;
        rd      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid && any_op) begin
                    acc_d   = rs1;
                    sel_d   = dec.sel;
                    cnt_d   = dec.iters;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Core withdrew the request: drop the op without a result.
                if (!valid) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = perm_y;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                rd      = XLEN'(acc_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_crypto_fu_ssm3_inv.sv
// ---------------------------------------------------------------------------
// tb_riscv_crypto_fu_ssm3_inv
//  Directed + randomized-operand bench. The driver records, for each issued
//  op, the cycle in which ready must appear and the value rd must carry; a
//  single per-cycle compare process checks ready/rd against that schedule.
// ---------------------------------------------------------------------------
module tb_riscv_crypto_fu_ssm3_inv;

    localparam int unsigned XLEN = 64;
    localparam int MAX_CYC = 100000;

    // Op masks: bit0=p0, bit1=p1, bit2=p0i, bit3=p1i.
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_P0   = 4'b0001;
    localparam logic [3:0] OP_P1   = 4'b0010;
    localparam logic [3:0] OP_P0I  = 4'b0100;
    localparam logic [3:0] OP_P1I  = 4'b1000;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            valid;
    logic [31:0]     rs1;
    logic            op_ssm3_p0;
    logic            op_ssm3_p1;
    logic            op_ssm3_p0i;
    logic            op_ssm3_p1i;
    logic            ready;
    logic [XLEN-1:0] rd;

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          exp_cyc = -1;
    logic [31:0] exp_val = '0;
    bit          chk_en  = 1'b0;
    string       tag     = "reset";

    logic [XLEN-1:0] want_rd;
    logic            want_rdy;

    riscv_crypto_fu_ssm3_inv #(.XLEN(XLEN)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .valid       (valid),
        .rs1         (rs1),
        .op_ssm3_p0  (op_ssm3_p0),
        .op_ssm3_p1  (op_ssm3_p1),
        .op_ssm3_p0i (op_ssm3_p0i),
        .op_ssm3_p1i (op_ssm3_p1i),
        .ready       (ready),
        .rd          (rd)
    );

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    // Watchdog: the run must finish within a bounded number of cycles.
    always @(posedge g_clk) begin
        if (cyc > MAX_CYC) begin
            errors++;
            $display("FAIL timeout: wait expired at cyc=%0d (tag %s)", cyc, tag);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Model: bitwise definition of one permutation step (y[i] = x[i] ^ x[i-a] ^ x[i-b]).
    function automatic logic [31:0] m_step(input logic [31:0] x, input bit is_p1);
        logic [31:0] y;
        int a;
        int b;
        a = is_p1 ? 15 : 9;
        b = is_p1 ? 23 : 17;
        for (int i = 0; i < 32; i++)
            y[i] = x[i] ^ x[(i - a + 32) % 32] ^ x[(i - b + 32) % 32];
        return y;
    endfunction

    // Model: op semantics with the priority p0i > p1i > p0 > p1.
    function automatic logic [31:0] m_op(input logic [3:0] ops, input logic [31:0] x);
        logic [31:0] y;
        bit is_p1;
        int n;
        y = x;
        if (ops[2])      begin is_p1 = 1'b0; n = 3; end
        else if (ops[3]) begin is_p1 = 1'b1; n = 3; end
        else if (ops[0]) begin is_p1 = 1'b0; n = 1; end
        else             begin is_p1 = 1'b1; n = 1; end
        for (int k = 0; k < n; k++) y = m_step(y, is_p1);
        return y;
    endfunction

    function automatic int m_lat(input logic [3:0] ops);
        return (ops[2] || ops[3]) ? 4 : 2;
    endfunction

    // Per-cycle check of ready/rd against the scheduled expectation.
    always @(negedge g_clk) begin
        if (chk_en) begin
            want_rdy = (cyc == exp_cyc);
            want_rd  = want_rdy ? XLEN'(exp_val) : '0;
            checks++;
            if (ready !== want_rdy || rd !== want_rd) begin
                errors++;
                $display("FAIL %s cyc=%0d: got ready=%0b rd=%h, expected ready=%0b rd=%h",
                         tag, cyc, ready, rd, want_rdy, want_rd);
            end
        end
    end

    // Outputs must be in their reset state right after a reset edge.
    task automatic check_reset(input string name);
        checks++;
        if (ready !== 1'b0 || rd !== '0) begin
            errors++;
            $display("FAIL %s: after reset got ready=%0b rd=%h, expected ready=0 rd=0",
                     name, ready, rd);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #2;
    endtask

    task automatic set_ops(input logic [3:0] ops);
        {op_ssm3_p1i, op_ssm3_p0i, op_ssm3_p1, op_ssm3_p0} = ops;
    endtask

    // Issue an op in the next cycle and hold valid until its ready cycle.
    task automatic issue(input string name, input logic [3:0] ops, input logic [31:0] x,
                         input bit use_lit, input logic [31:0] lit, input bit scramble);
        int t;
        int lat;
        step();
        tag   = name;
        lat   = m_lat(ops);
        valid = 1'b1;
        rs1   = x;
        set_ops(ops);
        t       = cyc;
        exp_val = use_lit ? lit : m_op(ops, x);
        exp_cyc = t + lat;
        for (int k = 1; k <= lat; k++) begin
            step();
            if (scramble) begin
                rs1 = $urandom;
                set_ops(4'($urandom));
            end
        end
    endtask

    // Issue an op, then drop valid in cycle T+a (a inside the RUN window).
    task automatic issue_abort(input string name, input logic [3:0] ops, input logic [31:0] x,
                               input int a);
        step();
        tag     = name;
        exp_cyc = -1;
        valid   = 1'b1;
        rs1     = x;
        set_ops(ops);
        for (int k = 1; k <= a; k++) step();
        valid = 1'b0;
        set_ops(OP_NONE);
    endtask

    task automatic go_idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            tag   = "idle";
            valid = 1'b0;
            rs1   = '0;
            set_ops(OP_NONE);
        end
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] r;

        g_reset = 1'b1;
        valid   = 1'b0;
        rs1     = '0;
        set_ops(OP_NONE);
        step();
        check_reset("reset_init");
        chk_en = 1'b1;
        step();
        g_reset = 1'b0;
        go_idle(2);

        // Forward ops, hand-computed results.
        issue("p0_one",  OP_P0,  32'h0000_0001, 1'b1, 32'h0002_0201, 1'b0);
        go_idle(1);
        issue("p1_one",  OP_P1,  32'h0000_0001, 1'b1, 32'h0080_8001, 1'b0);

        // Inverse ops, back-to-back.
        issue("p0i_inv", OP_P0I, 32'h0002_0201, 1'b1, 32'h0000_0001, 1'b0);
        issue("p1i_inv", OP_P1I, 32'h0080_8001, 1'b1, 32'h0000_0001, 1'b0);
        issue("p0i_one", OP_P0I, 32'h0000_0001, 1'b0, 32'h0,         1'b0);
        go_idle(1);

        // All-ones and zero are fixed points of every op.
        issue("p0i_ones", OP_P0I, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        issue("p1i_ones", OP_P1I, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        issue("p0i_zero", OP_P0I, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
        issue("p1i_zero", OP_P1I, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
        go_idle(1);

        // valid with no op bit: never accepted.
        step();
        tag     = "no_op";
        exp_cyc = -1;
        valid   = 1'b1;
        rs1     = 32'hDEAD_BEEF;
        set_ops(OP_NONE);
        go_idle(4);

        // Multi-hot priority.
        issue("prio_p0_p1",   OP_P0 | OP_P1,   32'h0000_0001, 1'b1, 32'h0002_0201, 1'b0);
        issue("prio_p1_p1i",  OP_P1 | OP_P1I,  32'h0080_8001, 1'b1, 32'h0000_0001, 1'b0);
        issue("prio_all",     4'b1111,         32'h0002_0201, 1'b1, 32'h0000_0001, 1'b0);
        go_idle(1);

        // Abort in RUN, then an immediate new op with exact latency.
        issue_abort("abort_p1i", OP_P1I, 32'h1234_5678, 2);
        issue("after_abort", OP_P0, 32'h0000_0001, 1'b1, 32'h0002_0201, 1'b0);
        issue_abort("abort_p0_early", OP_P0, 32'h0000_0001, 1);
        issue("after_abort2", OP_P1I, 32'h0080_8001, 1'b1, 32'h0000_0001, 1'b0);
        go_idle(1);

        // Reset mid-op.
        step();
        tag     = "reset_mid";
        exp_cyc = -1;
        valid   = 1'b1;
        rs1     = 32'h0002_0201;
        set_ops(OP_P0I);
        step();
        g_reset = 1'b1;
        step();
        check_reset("reset_mid");
        g_reset = 1'b0;
        valid   = 1'b0;
        set_ops(OP_NONE);
        go_idle(4);
        issue("after_reset", OP_P1, 32'h0000_0001, 1'b1, 32'h0080_8001, 1'b0);
        go_idle(1);

        // Round trips with operand/op scrambling during RUN.
        for (int i = 0; i < 2000; i++) begin
            x = $urandom;
            r = m_op(OP_P0I, x);
            issue("rt_p0i", OP_P0I, x, 1'b0, 32'h0, 1'b1);
            issue("rt_p0",  OP_P0,  r, 1'b1, x,     1'b1);
            r = m_op(OP_P1I, x);
            issue("rt_p1i", OP_P1I, x, 1'b0, 32'h0, 1'b1);
            issue("rt_p1",  OP_P1,  r, 1'b1, x,     1'b1);
        end
        go_idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
